// File: rtl/ex_iter_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, result classes,
// register/write constants and the divider state codes.
package ex_iter_pkg;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_iter_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, operands captured
// at start, signed results recovered from magnitudes in the END state.
module div_iter
  import ex_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opa_i,
  input  logic [DATA_W-1:0]   opb_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] opa_mag, opb_mag;
  logic              opa_neg, opb_neg;

  assign opa_neg = signed_div_i & opa_i[DATA_W-1];
  assign opb_neg = signed_div_i & opb_i[DATA_W-1];
  assign opa_mag = opa_neg ? (~opa_i + 1'b1) : opa_i;
  assign opb_mag = opb_neg ? (~opb_i + 1'b1) : opb_i;

  // Partial remainder can reach 2*divisor-1, hence the extra bit; its MSB is the borrow.
  assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (annul_i) begin
      state_d = DIV_FREE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = opa_mag;
            dvs_d     = opb_mag;
            neg_quo_d = opa_neg ^ opb_neg;
            neg_rem_d = opa_neg;
            state_d   = (opb_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          rem_d     = '0;
          quo_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          state_d   = DIV_END;
        end
        DIV_ON: begin
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DIV_END;
          end
        end
        DIV_END: begin
          state_d = DIV_FREE;
        end
        default: begin
          state_d = DIV_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // The most negative dividend over -1 wraps back to itself, matching the no-trap behaviour.
  assign result_o = {(neg_rem_q ? (~rem_q + 1'b1) : rem_q),
                     (neg_quo_q ? (~quo_q + 1'b1) : quo_q)};
  assign ready_o  = (state_q == DIV_END);

endmodule

// File: rtl/ex_iter.sv
// MIPS execute stage: combinational ALU for single-cycle ops, iterative
// divider for DIV/DIVU with a stall request while the divider works.
module ex_iter
  import ex_iter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              annul_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   logic_res, shift_res, arith_res, sel_res;
  logic [SH_W-1:0]     shamt;
  logic                op_known;
  logic                is_div, div_start, div_ready, force_off;
  logic [2*DATA_W-1:0] div_result;

  assign shamt     = reg2_i[SH_W-1:0];
  assign is_div    = is_div_op(aluop_i);
  assign div_start = is_div & ~annul_i;
  // rst is sampled combinationally here so outputs drop as soon as reset asserts.
  assign force_off = ~rst | annul_i;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_logic_bit
      assign logic_res[gi] =
          (aluop_i == EXE_OR_OP)  ?  (reg1_i[gi] | reg2_i[gi]) :
          (aluop_i == EXE_AND_OP) ?  (reg1_i[gi] & reg2_i[gi]) :
          (aluop_i == EXE_XOR_OP) ?  (reg1_i[gi] ^ reg2_i[gi]) :
          (aluop_i == EXE_NOR_OP) ? ~(reg1_i[gi] | reg2_i[gi]) : 1'b0;
    end
  endgenerate

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg1_i << shamt;
      EXE_SRL_OP: shift_res = reg1_i >> shamt;
      EXE_SRA_OP: shift_res = $signed(reg1_i) >>> shamt;
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    op_known = 1'b0;
    case (aluop_i)
      EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP,
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
      EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP: op_known = 1'b1;
      default:                                           op_known = 1'b0;
    endcase
  end

  always_comb begin
    sel_res = '0;
    case (alusel_i)
      EXE_RES_LOGIC: sel_res = logic_res;
      EXE_RES_SHIFT: sel_res = shift_res;
      EXE_RES_ARITH: sel_res = arith_res;
      default:       sel_res = '0;
    endcase
  end

  div_iter #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk          (clk),
    .rst          (rst),
    .start_i      (div_start),
    .signed_div_i (aluop_i == EXE_DIV_OP),
    .opa_i        (reg1_i),
    .opb_i        (reg2_i),
    .annul_i      (annul_i),
    .result_o     (div_result),
    .ready_o      (div_ready)
  );

  always_comb begin
    wd_o       = '0;
    wreg_o     = WRITE_DISABLE;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!force_off) begin
      wd_o = wd_i;
      if (op_known) begin
        wreg_o  = wreg_i;
        wdata_o = sel_res;
      end
      // Divider results only go to HI/LO; the GPR write stays disabled.
      if (div_ready) begin
        whilo_o = 1'b1;
        hi_o    = div_result[2*DATA_W-1:DATA_W];
        lo_o    = div_result[DATA_W-1:0];
      end
      stallreq_o = is_div & ~div_ready;
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// Directed bench for ex_iter: single-cycle ALU vectors, divider latency and
// results, annul and asynchronous reset behaviour.
module tb_ex_iter;
  import ex_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_iter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .annul_i    (annul_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wd"},    64'(wd_o), 64'h0);
    check({tag, ".wreg"},  64'(wreg_o), 64'h0);
    check({tag, ".wdata"}, 64'(wdata_o), 64'h0);
    check({tag, ".whilo"}, 64'(whilo_o), 64'h0);
    check({tag, ".hilo"},  {hi_o, lo_o}, 64'h0);
    check({tag, ".stall"}, 64'(stallreq_o), 64'h0);
  endtask

  // Issues a divide and counts stall cycles; perturb changes the operands mid-run.
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input bit perturb);
    int stall_cnt;
    stall_cnt = 0;
    drive(op, EXE_RES_NOP, a, b, 5'd9, 1'b1);
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!stallreq_o) break;
      stall_cnt++;
      if (perturb && stall_cnt == 5) begin
        reg1_i = 32'h1234_5678;
        reg2_i = 32'h0000_0003;
      end
      tick();
    end
    check({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, ".whilo"}, 64'(whilo_o), 64'h1);
    check({tag, ".lo"},    64'(lo_o), 64'(exp_lo));
    check({tag, ".hi"},    64'(hi_o), 64'(exp_hi));
    check({tag, ".wreg"},  64'(wreg_o), 64'h0);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check({tag, ".whilo_after"}, 64'(whilo_o), 64'h0);
    check({tag, ".stall_after"}, 64'(stallreq_o), 64'h0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_wreg;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"OR",   EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F000, 32'h00F0_FF00, 1'b1};
    vecs[1]  = '{"AND",  EXE_AND_OP,  EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F000, 32'h0000_F000, 1'b1};
    vecs[2]  = '{"XOR",  EXE_XOR_OP,  EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F000, 32'h00F0_0F00, 1'b1};
    vecs[3]  = '{"NOR",  EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F000, 32'hFF0F_00FF, 1'b1};
    vecs[4]  = '{"SLT",  EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
    vecs[5]  = '{"SLTU", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[6]  = '{"SRA",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b1};
    vecs[7]  = '{"SRL",  EXE_SRL_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b1};
    vecs[8]  = '{"SLL31",EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b1};
    vecs[9]  = '{"SLLlo",EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b1};
    vecs[10] = '{"ADDU", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
    vecs[11] = '{"SUBU", EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{"UNK",  8'hFF,       EXE_RES_LOGIC, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0};

    rst     = 1'b0;
    annul_i = 1'b0;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F000, 5'd5, 1'b1);
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'd5, 1'b1);
      #1;
      check({vecs[i].name, ".wdata"}, 64'(wdata_o), 64'(vecs[i].exp));
      check({vecs[i].name, ".wreg"},  64'(wreg_o), 64'(vecs[i].exp_wreg));
      check({vecs[i].name, ".wd"},    64'(wd_o), 64'h5);
      check({vecs[i].name, ".stall"}, 64'(stallreq_o | whilo_o), 64'h0);
    end
    tick();

    run_div("DIVU_100_7",   EXE_DIVU_OP, 32'd100,       32'd7,         33, 32'd14,        32'd2,         1'b1);
    run_div("DIV_m7_2",     EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("DIV_7_m2",     EXE_DIV_OP,  32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run_div("DIV_min_m1",   EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0,         1'b0);
    run_div("DIVU_max_16",  EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10,        33, 32'h0FFF_FFFF, 32'hF,         1'b0);
    run_div("DIV_5_0",      EXE_DIV_OP,  32'd5,         32'd0,         2,  32'h0,         32'h0,         1'b0);

    // Annul in the middle of a divide, then a clean divide afterwards.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
    #1;
    repeat (10) tick();
    annul_i = 1'b1;
    #1;
    check_all_zero("annul_mid");
    tick();
    annul_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check("annul_idle.stall", 64'(stallreq_o), 64'h0);
    check("annul_idle.whilo", 64'(whilo_o), 64'h0);
    tick();
    run_div("DIVU_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

    // Annul wins over a divide issued in the same cycle.
    annul_i = 1'b1;
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd5, 32'd0, 5'd9, 1'b1);
    #1;
    check("annul_issue.stall", 64'(stallreq_o), 64'h0);
    tick();
    annul_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check("annul_issue.whilo", 64'(whilo_o), 64'h0);

    // Asynchronous reset mid-divide, away from any clock edge.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd50, 32'd5, 5'd9, 1'b1);
    #1;
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    run_div("DIVU_9_3_post_rst", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
